// File: rtl/pcie_rc_rx.sv
// rtl/pcie_rc_rx.sv - requester-completion receive stage for Type 0 config reads
// Matches the armed tag, drains/counts stray completions, times out lost reads.
module pcie_rc_rx #(
    parameter int C_DATA_WIDTH   = 512,
    parameter int KEEP_WIDTH     = C_DATA_WIDTH / 32,
    parameter int TIMEOUT_CYCLES = 250000
) (
    input  logic                    user_clk,
    input  logic                    user_reset,
    input  logic                    user_lnk_up,
    input  logic [C_DATA_WIDTH-1:0] m_axis_rc_tdata,
    input  logic [160:0]            m_axis_rc_tuser,
    input  logic [KEEP_WIDTH-1:0]   m_axis_rc_tkeep,
    input  logic                    m_axis_rc_tlast,
    input  logic                    m_axis_rc_tvalid,
    output logic                    m_axis_rc_tready,
    input  logic                    ctr2rx_type0_cfg_read,
    input  logic [7:0]              ctr2rx_type0_cfg_read_tag,
    output logic                    rx2ctr_type0_cfg_read_done,
    output logic [31:0]             rx2ctr_type0_cfg_read_data,
    output logic [2:0]              rx2ctr_type0_cfg_read_status,
    output logic [3:0]              rx2ctr_type0_cfg_read_err,
    output logic                    rx2ctr_type0_cfg_read_poisoned,
    output logic                    rx2ctr_type0_cfg_read_timeout,
    output logic [15:0]             rx2ctr_unexp_cpl_cnt
);

    localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN, DONE} state_t;

    state_t      state;
    logic [7:0]  tag_q;
    logic [23:0] cnt;
    logic        armed;
    logic        report;
    logic        tmo_pend;
    logic [31:0] lat_data;
    logic [2:0]  lat_status;
    logic [3:0]  lat_err;
    logic        lat_poison;

    logic        beat;
    logic        sop;
    logic        disc;
    logic        match;
    logic [2:0]  cpl_status;
    logic [31:0] cpl_data;
    logic        cpl_poison;
    logic        unexp;
    logic        expire;
    logic        unused_bits;

    assign beat       = m_axis_rc_tvalid && m_axis_rc_tready;
    assign sop        = beat && m_axis_rc_tuser[64];
    assign disc       = m_axis_rc_tuser[96];
    assign match      = m_axis_rc_tdata[71:64] == tag_q;
    assign cpl_status = m_axis_rc_tdata[45:43];
    // Non-successful completions carry no meaningful payload.
    assign cpl_data   = (cpl_status == 3'b000) ? m_axis_rc_tdata[127:96] : 32'h0;
    assign cpl_poison = m_axis_rc_tdata[46] | disc;
    assign expire     = (cnt >= TMO_LAST) || !user_lnk_up;

    assign unused_bits = ^{m_axis_rc_tkeep, m_axis_rc_tuser[160:97], m_axis_rc_tuser[95:65],
                           m_axis_rc_tuser[63:0], m_axis_rc_tdata[C_DATA_WIDTH-1:128],
                           m_axis_rc_tdata[95:72], m_axis_rc_tdata[63:47],
                           m_axis_rc_tdata[42:16], m_axis_rc_tdata[11:0]};

    always_comb begin
        unexp = 1'b0;
        if (sop && state != DRAIN && !(state == WAIT && match))
            unexp = 1'b1;
    end

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            state                          <= IDLE;
            tag_q                          <= 8'h0;
            cnt                            <= 24'h0;
            armed                          <= 1'b0;
            report                         <= 1'b0;
            tmo_pend                       <= 1'b0;
            lat_data                       <= 32'h0;
            lat_status                     <= 3'b000;
            lat_err                        <= 4'h0;
            lat_poison                     <= 1'b0;
            m_axis_rc_tready               <= 1'b0;
            rx2ctr_type0_cfg_read_done     <= 1'b0;
            rx2ctr_type0_cfg_read_data     <= 32'h0;
            rx2ctr_type0_cfg_read_status   <= 3'b000;
            rx2ctr_type0_cfg_read_err      <= 4'h0;
            rx2ctr_type0_cfg_read_poisoned <= 1'b0;
            rx2ctr_type0_cfg_read_timeout  <= 1'b0;
            rx2ctr_unexp_cpl_cnt           <= 16'h0;
        end else begin
            m_axis_rc_tready           <= 1'b1;
            rx2ctr_type0_cfg_read_done <= 1'b0;
            if (unexp && rx2ctr_unexp_cpl_cnt != 16'hFFFF)
                rx2ctr_unexp_cpl_cnt <= rx2ctr_unexp_cpl_cnt + 16'd1;

            case (state)
                IDLE: begin
                    if (ctr2rx_type0_cfg_read) begin
                        tag_q    <= ctr2rx_type0_cfg_read_tag;
                        cnt      <= 24'h0;
                        armed    <= 1'b1;
                        tmo_pend <= 1'b0;
                        state    <= WAIT;
                    end
                    if (sop && !m_axis_rc_tlast) begin
                        report <= 1'b0;
                        state  <= DRAIN;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 24'd1;
                    if (sop && match) begin
                        lat_data   <= cpl_data;
                        lat_status <= cpl_status;
                        lat_err    <= m_axis_rc_tdata[15:12];
                        lat_poison <= cpl_poison;
                        if (m_axis_rc_tlast) begin
                            rx2ctr_type0_cfg_read_done     <= 1'b1;
                            rx2ctr_type0_cfg_read_data     <= cpl_data;
                            rx2ctr_type0_cfg_read_status   <= cpl_status;
                            rx2ctr_type0_cfg_read_err      <= m_axis_rc_tdata[15:12];
                            rx2ctr_type0_cfg_read_poisoned <= cpl_poison;
                            rx2ctr_type0_cfg_read_timeout  <= 1'b0;
                            state                          <= DONE;
                        end else begin
                            report <= 1'b1;
                            state  <= DRAIN;
                        end
                    end else if (sop && !m_axis_rc_tlast) begin
                        // A stray TLP straddling the deadline reports the timeout at its tlast.
                        report   <= 1'b0;
                        tmo_pend <= expire;
                        state    <= DRAIN;
                    end else if (expire) begin
                        rx2ctr_type0_cfg_read_done     <= 1'b1;
                        rx2ctr_type0_cfg_read_data     <= 32'hFFFF_FFFF;
                        rx2ctr_type0_cfg_read_status   <= 3'b001;
                        rx2ctr_type0_cfg_read_err      <= 4'h0;
                        rx2ctr_type0_cfg_read_poisoned <= 1'b0;
                        rx2ctr_type0_cfg_read_timeout  <= 1'b1;
                        state                          <= DONE;
                    end
                end
                DRAIN: begin
                    if (armed) begin
                        if (cnt >= TMO_LAST) tmo_pend <= 1'b1;
                        else                 cnt      <= cnt + 24'd1;
                    end
                    if (beat && report) lat_poison <= lat_poison | disc;
                    if (beat && m_axis_rc_tlast) begin
                        if (report) begin
                            rx2ctr_type0_cfg_read_done     <= 1'b1;
                            rx2ctr_type0_cfg_read_data     <= lat_data;
                            rx2ctr_type0_cfg_read_status   <= lat_status;
                            rx2ctr_type0_cfg_read_err      <= lat_err;
                            rx2ctr_type0_cfg_read_poisoned <= lat_poison | disc;
                            rx2ctr_type0_cfg_read_timeout  <= 1'b0;
                            state                          <= DONE;
                        end else if (armed && (tmo_pend || cnt >= TMO_LAST)) begin
                            rx2ctr_type0_cfg_read_done     <= 1'b1;
                            rx2ctr_type0_cfg_read_data     <= 32'hFFFF_FFFF;
                            rx2ctr_type0_cfg_read_status   <= 3'b001;
                            rx2ctr_type0_cfg_read_err      <= 4'h0;
                            rx2ctr_type0_cfg_read_poisoned <= 1'b0;
                            rx2ctr_type0_cfg_read_timeout  <= 1'b1;
                            state                          <= DONE;
                        end else if (armed) begin
                            state <= WAIT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DONE: begin
                    armed    <= 1'b0;
                    report   <= 1'b0;
                    tmo_pend <= 1'b0;
                    state    <= IDLE;
                    // A TLP starting here is stray; drain it while disarmed.
                    if (sop && !m_axis_rc_tlast) state <= DRAIN;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pcie_rc_rx.sv
// tb/tb_pcie_rc_rx.sv - self-checking bench for pcie_rc_rx
`timescale 1ns/1ps
module tb_pcie_rc_rx;

    localparam int DW = 512;
    localparam int KW = DW / 32;
    localparam int T  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          lnk = 1'b1;
    logic [DW-1:0] tdata = '0;
    logic [160:0]  tuser = '0;
    logic [KW-1:0] tkeep = '1;
    logic          tlast = 1'b0;
    logic          tvalid = 1'b0;
    logic          tready;
    logic          arm = 1'b0;
    logic [7:0]    arm_tag = 8'h0;
    logic          done;
    logic [31:0]   data;
    logic [2:0]    status;
    logic [3:0]    err;
    logic          poisoned;
    logic          timeout;
    logic [15:0]   unexp;

    int checks = 0;
    int errors = 0;
    int unexp_exp = 0;

    pcie_rc_rx #(.C_DATA_WIDTH(DW), .KEEP_WIDTH(KW), .TIMEOUT_CYCLES(T)) dut (
        .user_clk(clk), .user_reset(rst), .user_lnk_up(lnk),
        .m_axis_rc_tdata(tdata), .m_axis_rc_tuser(tuser), .m_axis_rc_tkeep(tkeep),
        .m_axis_rc_tlast(tlast), .m_axis_rc_tvalid(tvalid), .m_axis_rc_tready(tready),
        .ctr2rx_type0_cfg_read(arm), .ctr2rx_type0_cfg_read_tag(arm_tag),
        .rx2ctr_type0_cfg_read_done(done), .rx2ctr_type0_cfg_read_data(data),
        .rx2ctr_type0_cfg_read_status(status), .rx2ctr_type0_cfg_read_err(err),
        .rx2ctr_type0_cfg_read_poisoned(poisoned), .rx2ctr_type0_cfg_read_timeout(timeout),
        .rx2ctr_unexp_cpl_cnt(unexp)
    );

    always #5 clk = ~clk;

    // Drive one beat at a negedge, leave it for one rising edge, return at the next negedge.
    task automatic drive_beat(input bit sop, input bit last, input logic [7:0] tag,
                              input logic [2:0] st, input logic [3:0] er, input bit ep,
                              input logic [31:0] dw, input bit disc);
        for (int w = 0; w < DW / 32; w++) tdata[w*32 +: 32] = $urandom;
        for (int w = 0; w < 5; w++) tuser[w*32 +: 32] = $urandom;
        tuser[160] = 1'($urandom);
        tuser[64] = sop;
        tuser[96] = disc;
        if (sop) begin
            tdata[71:64]  = tag;
            tdata[45:43]  = st;
            tdata[15:12]  = er;
            tdata[46]     = ep;
            tdata[127:96] = dw;
        end
        tlast  = last;
        tvalid = 1'b1;
        @(negedge clk);
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic send_tlp(input logic [7:0] tag, input int nb, input logic [2:0] st,
                            input logic [3:0] er, input bit ep, input logic [31:0] dw,
                            input bit disc_last, input bit gaps);
        for (int b = 0; b < nb; b++) begin
            if (gaps && ($urandom % 2 == 1)) @(negedge clk);
            drive_beat(b == 0, b == nb - 1, tag, st, er, ep, dw, (b == nb - 1) && disc_last);
        end
    endtask

    task automatic do_arm(input logic [7:0] tag);
        arm = 1'b1;
        arm_tag = tag;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tready !== 1'b0) begin errors++; $display("FAIL reset_tready got=%0b exp=0", tready); end
        checks++; if ({done, data, status, err, poisoned, timeout, unexp} !== '0) begin
            errors++; $display("FAIL reset_outputs got done=%0b data=%h st=%0d err=%0d p=%0b t=%0b u=%0d exp all 0",
                               done, data, status, err, poisoned, timeout, unexp);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (tready !== 1'b1) begin errors++; $display("FAIL reset_release_tready got=%0b exp=1", tready); end
    endtask

    task automatic test_single_match(input string name);
        do_arm(8'h05);
        send_tlp(8'h05, 1, 3'b000, 4'h0, 1'b0, 32'h1234_10EC, 1'b0, 1'b0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s_done got=%0b exp=1", name, done); end
        checks++; if (data !== 32'h1234_10EC || status !== 3'b000 || timeout !== 1'b0 || poisoned !== 1'b0) begin
            errors++; $display("FAIL %s_result got data=%h st=%0d t=%0b p=%0b exp data=123410ec st=0 t=0 p=0",
                               name, data, status, timeout, poisoned);
        end
        checks++; if (unexp !== 16'(unexp_exp)) begin errors++; $display("FAIL %s_unexp got=%0d exp=%0d", name, unexp, unexp_exp); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done_width got=%0b exp=0", name, done); end
    endtask

    task automatic test_unexpected;
        do_arm(8'h07);
        send_tlp(8'h08, 1, 3'b000, 4'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        unexp_exp++;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL unexp_no_done got=%0b exp=0", done); end
        send_tlp(8'h07, 1, 3'b001, 4'h3, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0);
        checks++; if (done !== 1'b1 || status !== 3'b001 || data !== 32'h0 || err !== 4'h3) begin
            errors++; $display("FAIL unexp_result got done=%0b st=%0d data=%h err=%0d exp done=1 st=1 data=0 err=3",
                               done, status, data, err);
        end
        checks++; if (unexp !== 16'(unexp_exp)) begin errors++; $display("FAIL unexp_count got=%0d exp=%0d", unexp, unexp_exp); end
        @(negedge clk);
    endtask

    task automatic test_timeout;
        int n = 0;
        arm = 1'b1;
        arm_tag = 8'h11;
        while (n < 40) begin
            @(negedge clk);
            arm = 1'b0;
            n++;
            if (done === 1'b1) break;
        end
        checks++; if (n != T + 1) begin errors++; $display("FAIL timeout_latency got=%0d exp=%0d", n, T + 1); end
        checks++; if (data !== 32'hFFFF_FFFF || status !== 3'b001 || timeout !== 1'b1) begin
            errors++; $display("FAIL timeout_result got data=%h st=%0d t=%0b exp data=ffffffff st=1 t=1", data, status, timeout);
        end
        @(negedge clk);
    endtask

    task automatic test_multibeat;
        logic [31:0] dw = $urandom;
        do_arm(8'h2A);
        drive_beat(1'b1, 1'b0, 8'h2A, 3'b000, 4'h0, 1'b1, dw, 1'b0);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL multi_beat1 got=%0b exp=0", done); end
        drive_beat(1'b0, 1'b0, 8'h00, 3'b000, 4'h0, 1'b0, 32'h0, 1'b0);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL multi_beat2 got=%0b exp=0", done); end
        drive_beat(1'b0, 1'b1, 8'h00, 3'b000, 4'h0, 1'b0, 32'h0, 1'b0);
        checks++; if (done !== 1'b1 || poisoned !== 1'b1 || data !== dw || timeout !== 1'b0) begin
            errors++; $display("FAIL multi_result got done=%0b p=%0b data=%h t=%0b exp done=1 p=1 data=%h t=0",
                               done, poisoned, data, timeout, dw);
        end
        @(negedge clk);
    endtask

    task automatic test_link_down;
        do_arm(8'h07);
        lnk = 1'b0;
        @(negedge clk);
        lnk = 1'b1;
        checks++; if (done !== 1'b1 || timeout !== 1'b1 || data !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL link_down got done=%0b t=%0b data=%h exp done=1 t=1 data=ffffffff", done, timeout, data);
        end
        @(negedge clk);
        send_tlp(8'h07, 2, 3'b000, 4'h0, 1'b0, 32'h1, 1'b0, 1'b0);
        unexp_exp++;
        checks++; if (done !== 1'b0 || unexp !== 16'(unexp_exp)) begin
            errors++; $display("FAIL link_late_cpl got done=%0b unexp=%0d exp done=0 unexp=%0d", done, unexp, unexp_exp);
        end
    endtask

    task automatic test_drain_timeout;
        do_arm(8'h10);
        for (int b = 0; b < 20; b++) begin
            drive_beat(b == 0, b == 19, 8'h11, 3'b000, 4'h0, 1'b0, 32'h0, 1'b0);
            if (b < 19 && done !== 1'b0) begin
                checks++; errors++; $display("FAIL drain_early_done beat=%0d got=1 exp=0", b);
            end
        end
        unexp_exp++;
        checks++; if (done !== 1'b1 || timeout !== 1'b1 || unexp !== 16'(unexp_exp)) begin
            errors++; $display("FAIL drain_timeout got done=%0b t=%0b unexp=%0d exp done=1 t=1 unexp=%0d",
                               done, timeout, unexp, unexp_exp);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        do_arm(8'h33);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({done, tready, data, status, err, poisoned, timeout, unexp} !== '0) begin
            errors++; $display("FAIL reset_mid got done=%0b rdy=%0b data=%h st=%0d u=%0d exp all 0",
                               done, tready, data, status, unexp);
        end
        rst = 1'b0;
        unexp_exp = 0;
        @(negedge clk);
        checks++; if (tready !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL reset_mid_release got rdy=%0b done=%0b exp rdy=1 done=0", tready, done);
        end
        test_single_match("after_reset");
    endtask

    task automatic test_random;
        for (int it = 0; it < 24; it++) begin
            logic [7:0]  tag = 8'($urandom);
            logic [2:0]  st  = ($urandom % 3 == 0) ? 3'($urandom) : 3'b000;
            logic [3:0]  er  = 4'($urandom);
            bit          ep  = 1'($urandom);
            bit          dsc = ($urandom % 4 == 0);
            logic [31:0] dw  = $urandom;
            int          len = 1 + $urandom % 3;
            logic [31:0] exp_data;
            if ($urandom % 3 == 0) begin
                send_tlp(8'($urandom), 1 + $urandom % 2, 3'b000, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0);
                unexp_exp++;
            end
            do_arm(tag);
            if ($urandom % 2 == 1) begin
                send_tlp(tag ^ 8'(1 + $urandom % 255), 1 + $urandom % 3, 3'b000, 4'h0, 1'b0, 32'h0, 1'b0, 1'b1);
                unexp_exp++;
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL rand_stray_done it=%0d got=1 exp=0", it); end
            end
            send_tlp(tag, len, st, er, ep, dw, dsc, 1'b1);
            exp_data = (st == 3'b000) ? dw : 32'h0;
            checks++; if (done !== 1'b1 || data !== exp_data || status !== st || err !== er ||
                          poisoned !== (ep | dsc) || timeout !== 1'b0 || unexp !== 16'(unexp_exp)) begin
                errors++; $display("FAIL rand_cpl it=%0d got done=%0b data=%h st=%0d err=%0d p=%0b t=%0b u=%0d exp done=1 data=%h st=%0d err=%0d p=%0b t=0 u=%0d",
                                   it, done, data, status, err, poisoned, timeout, unexp,
                                   exp_data, st, er, ep | dsc, unexp_exp);
            end
            @(negedge clk);
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL rand_done_width it=%0d got=1 exp=0", it); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_single_match("single");
        test_unexpected;
        test_timeout;
        test_multibeat;
        test_link_down;
        test_drain_timeout;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
